// File: rtl/imm_pkg.sv
// imm_pkg: immediate format codes and base opcodes shared by the immediate generator
package imm_pkg;
  localparam int IMM_TYPE_W = 3;
  typedef enum logic [IMM_TYPE_W-1:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_SH
  } imm_type_e;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
endpackage

// File: rtl/imm_decode_comb.sv
// imm_decode_comb: combinational format decode and immediate extraction for one instruction
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]           instruction,
  output logic [XLEN-1:0]       imm,
  output logic [IMM_TYPE_W-1:0] imm_type,
  output logic                  illegal
);
  logic [6:0] opc;
  logic       rv64;
  logic       sh_f3;
  logic       narrow;
  imm_type_e  ty;
  assign opc    = instruction[6:0];
  assign rv64   = XLEN == 64;
  assign sh_f3  = instruction[13:12] == 2'b01;
  assign narrow = !rv64 || opc == OPC_OP_IMM32;
  // format select from opcode/funct3; RV64-only opcodes are illegal on a 32-bit datapath
  always_comb begin
    ty      = IMM_NONE;
    illegal = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: ty = IMM_U;
      OPC_JAL:            ty = IMM_J;
      OPC_JALR, OPC_LOAD: ty = IMM_I;
      OPC_OP_IMM:         ty = sh_f3 ? IMM_SH : IMM_I;
      OPC_OP_IMM32: begin
        ty      = !rv64 ? IMM_NONE : sh_f3 ? IMM_SH : IMM_I;
        illegal = !rv64;
      end
      OPC_STORE:          ty = IMM_S;
      OPC_BRANCH:         ty = IMM_B;
      OPC_SYSTEM:         ty = instruction[14] ? IMM_Z : IMM_NONE;
      OPC_OP, OPC_FENCE:  ty = IMM_NONE;
      OPC_OP32:           illegal = !rv64;
      default:            illegal = 1'b1;
    endcase
  end
  assign imm_type = ty;
  assign imm =
    ty == IMM_I  ? XLEN'($signed(instruction[31:20])) :
    ty == IMM_S  ? XLEN'($signed({instruction[31:25], instruction[11:7]})) :
    ty == IMM_B  ? XLEN'($signed({instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0})) :
    ty == IMM_U  ? XLEN'($signed({instruction[31:12], 12'b0})) :
    ty == IMM_J  ? XLEN'($signed({instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0})) :
    ty == IMM_Z  ? XLEN'(instruction[19:15]) :
    ty == IMM_SH ? XLEN'({instruction[25] & !narrow, instruction[24:20]}) :
    '0;
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with valid/ready handshake and a skid entry
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       imm,
  output logic [IMM_TYPE_W-1:0] imm_type,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  illegal_fmt
);
  localparam int W = XLEN + IMM_TYPE_W + TAG_W + 1;
  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  logic [XLEN-1:0]       d_imm;
  logic [IMM_TYPE_W-1:0] d_type;
  logic                  d_ill;
  logic [W-1:0]          d_word;
  logic [W-1:0]          main_word;
  logic [W-1:0]          sk_word;
  logic                  sk_valid;
  logic                  acc;
  logic                  drain;
  logic                  sk_nxt;
  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .instruction(instruction),
    .imm        (d_imm),
    .imm_type   (d_type),
    .illegal    (d_ill)
  );
  assign d_word = {d_imm, d_type, in_tag, d_ill};
  assign {imm, imm_type, out_tag, illegal_fmt} = main_word;
  assign acc    = in_valid && in_ready;
  assign drain  = !out_valid || out_ready;
  assign sk_nxt = !drain && (sk_valid || acc);
  // main output register: skid entry has priority over the input so order stays FIFO
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      main_word <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (drain) begin
      out_valid <= sk_valid || acc;
      main_word <= sk_valid ? sk_word : acc ? d_word : main_word;
    end
  end
  // skid entry catches a word accepted while main is stalled; in_ready is its registered inverse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sk_valid <= 1'b0;
      in_ready <= 1'b0;
      sk_word  <= '0;
    end else begin
      sk_valid <= !flush && sk_nxt;
      in_ready <= flush || !sk_nxt;
      sk_word  <= (!drain && acc) ? d_word : sk_word;
    end
  end
endmodule
